// File: rtl/unsigned_32_bit_serial_subtractor.sv
// Multi-cycle unsigned subtractor: in1 - in2 - bin, CHUNK bits per clock with a
// rippled borrow between chunks, behind a start/done handshake.
module unsigned_32_bit_serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             bout
);

    localparam int K     = WIDTH / CHUNK;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic             borrow;
    logic [CNT_W-1:0] cnt;

    logic [CHUNK:0]         step;
    logic [WIDTH+CHUNK-1:0] acc_shift;
    logic [WIDTH-1:0]       acc_next;

    // The top bit of the (CHUNK+1)-bit difference is the borrow out of the chunk.
    function automatic logic [CHUNK:0] sub_chunk(
        input logic [CHUNK-1:0] a,
        input logic [CHUNK-1:0] b,
        input logic             br
    );
        return {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, br};
    endfunction

    // Operands shift right one chunk per cycle, so the active chunk is always
    // the low CHUNK bits; result chunks enter at the top and move down.
    always_comb begin
        step      = sub_chunk(op_a[CHUNK-1:0], op_b[CHUNK-1:0], borrow);
        acc_shift = {step[CHUNK-1:0], acc} >> CHUNK;
        acc_next  = acc_shift[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dout   <= '0;
            bout   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_a   <= in1;
                        op_b   <= in2;
                        borrow <= bin;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    op_a   <= op_a >> CHUNK;
                    op_b   <= op_b >> CHUNK;
                    borrow <= step[CHUNK];
                    acc    <= acc_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        dout  <= acc_next;
                        bout  <= step[CHUNK];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unsigned_32_bit_serial_subtractor.sv
// Scoreboard bench for the serial subtractor: CHUNK=8 and CHUNK=4 instances,
// directed corner cases plus randomized operands against a full-width model.
module tb_unsigned_32_bit_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start8, c8, busy8, done8, bout8;
    logic [31:0] a8, b8, dout8;
    logic        start4, c4, busy4, done4, bout4;
    logic [31:0] a4, b4, dout4;

    unsigned_32_bit_serial_subtractor #(.WIDTH(32), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .in1(a8), .in2(b8), .bin(c8),
        .busy(busy8), .done(done8), .dout(dout8), .bout(bout8)
    );

    unsigned_32_bit_serial_subtractor #(.WIDTH(32), .CHUNK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .in1(a4), .in2(b4), .bin(c4),
        .busy(busy4), .done(done4), .dout(dout4), .bout(bout4)
    );

    int total = 0;
    int bad   = 0;
    logic [32:0] q8[$];
    logic [32:0] q4[$];
    logic [31:0] ld8 = '0, ld4 = '0;
    logic        lb8 = 1'b0, lb4 = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: full-width signed arithmetic; negative means a borrow out.
    function automatic logic [32:0] ref_sub(input logic [31:0] a, input logic [31:0] b, input logic c);
        longint      d;
        logic [63:0] u;
        d = longint'({32'b0, a}) - longint'({32'b0, b}) - longint'(c);
        u = d;
        return {d < 0, u[31:0]};
    endfunction

    function automatic logic [31:0] rw();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h1 << $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            ld8 = '0; lb8 = 1'b0;
        end else if (done8) begin
            if (q8.size() == 0) begin
                check("unexpected_done8", {31'b0, bout8, dout8}, 64'h0);
            end else begin
                logic [32:0] e;
                e = q8.pop_front();
                check("result8", {31'b0, bout8, dout8}, {31'b0, e});
            end
            ld8 = dout8; lb8 = bout8;
        end else begin
            check("hold8", {31'b0, bout8, dout8}, {31'b0, lb8, ld8});
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            ld4 = '0; lb4 = 1'b0;
        end else if (done4) begin
            if (q4.size() == 0) begin
                check("unexpected_done4", {31'b0, bout4, dout4}, 64'h0);
            end else begin
                logic [32:0] e;
                e = q4.pop_front();
                check("result4", {31'b0, bout4, dout4}, {31'b0, e});
            end
            ld4 = dout4; lb4 = bout4;
        end else begin
            check("hold4", {31'b0, bout4, dout4}, {31'b0, lb4, ld4});
        end
    end

    // Returns at the falling edge just after the accepting edge.
    task automatic issue8(input logic [31:0] a, input logic [31:0] b, input logic c, input bit hold);
        @(negedge clk);
        a8 = a; b8 = b; c8 = c; start8 = 1'b1;
        q8.push_back(ref_sub(a, b, c));
        @(negedge clk);
        if (!hold) start8 = 1'b0;
    endtask

    task automatic wait_done8(input int lat0, input string nm);
        int lat = lat0;
        int bcnt = lat0;
        while (!done8 && lat < 40) begin
            if (busy8) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (!done8) begin
            check({nm, "_timeout"}, 64'(done8), 64'h1);
        end else begin
            check({nm, "_latency"}, 64'(lat), 64'd4);
            check({nm, "_busy_cycles"}, 64'(bcnt), 64'd4);
            check({nm, "_busy_at_done"}, 64'(busy8), 64'h0);
        end
    endtask

    task automatic run_rand4();
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] a, b;
            logic        c;
            int          lat;
            a = rw(); b = rw(); c = 1'($urandom_range(0, 1));
            @(negedge clk);
            a4 = a; b4 = b; c4 = c; start4 = 1'b1;
            q4.push_back(ref_sub(a, b, c));
            @(negedge clk);
            start4 = 1'b0;
            lat = 0;
            while (!done4 && lat < 60) begin
                @(negedge clk);
                lat++;
            end
            check("rnd4_latency", 64'(lat), 64'd8);
        end
    endtask

    logic [31:0] da[6] = '{32'd1010, 32'd1000, 32'hFFFF_FFFF, 32'h0100_0000, 32'h0, 32'h8000_0000};
    logic [31:0] db[6] = '{32'd1000, 32'd1010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h0000_0001};
    logic        dc[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy8), 64'h0);
        check("rst_done", 64'(done8), 64'h0);
        check("rst_dout", 64'(dout8), 64'h0);
        check("rst_bout", 64'(bout8), 64'h0);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            issue8(da[i], db[i], dc[i], 1'b0);
            wait_done8(0, "directed");
        end

        // A start pulse during RUN must be ignored.
        issue8(32'd300, 32'd100, 1'b0, 1'b0);
        @(negedge clk);
        a8 = 32'd5; b8 = 32'd3; c8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(2, "ignore_start");

        // start held into the DONE cycle launches the next op with no gap.
        issue8(32'd20, 32'd7, 1'b0, 1'b0);
        a8 = 32'd5; b8 = 32'd3; c8 = 1'b0; start8 = 1'b1;
        wait_done8(0, "b2b_first");
        q8.push_back(ref_sub(32'd5, 32'd3, 1'b0));
        @(negedge clk);
        start8 = 1'b0;
        check("b2b_busy", 64'(busy8), 64'h1);
        wait_done8(0, "b2b_second");

        // Asynchronous reset in the middle of compute aborts the op.
        issue8(32'd1000, 32'd1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        q8.delete();
        #1;
        check("abort_busy", 64'(busy8), 64'h0);
        check("abort_done", 64'(done8), 64'h0);
        check("abort_dout", 64'(dout8), 64'h0);
        check("abort_bout", 64'(bout8), 64'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        issue8(32'd100, 32'd1, 1'b0, 1'b0);
        wait_done8(0, "after_reset");

        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    issue8(rw(), rw(), 1'($urandom_range(0, 1)), 1'b0);
                    wait_done8(0, "rnd8");
                end
            end
            run_rand4();
        join

        repeat (5) @(negedge clk);
        check("q8_drained", 64'(q8.size()), 64'h0);
        check("q4_drained", 64'(q4.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unsigned_32_bit_serial_subtractor.md
# unsigned_32_bit_serial_subtractor

Multi-cycle unsigned subtractor, the inverse companion to the team's 32-bit unsigned adder. It computes `in1 - in2 - bin` for unsigned operands and reports a borrow-out. It processes CHUNK bits per clock with a ripple borrow carried between chunks, behind a start/done handshake. It serves datapaths that trade latency for a short carry chain: one CHUNK-wide subtract per cycle instead of a full-width ripple.

## Interface
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits processed per cycle. WIDTH must be an integer multiple of CHUNK. K = WIDTH/CHUNK is the number of compute cycles.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled on rising clk edges only while idle or in the done cycle.
- in1  input  WIDTH  minuend; captured on the accepting edge.
- in2  input  WIDTH  subtrahend; captured on the accepting edge.
- bin  input  1  borrow-in; captured on the accepting edge.
- busy  output  1  high while an operation is in flight, from the accepting edge through the last compute edge.
- done  output  1  single-cycle pulse; dout and bout are valid in this cycle.
- dout  output  WIDTH  difference, (in1 - in2 - bin) mod 2^WIDTH.
- bout  output  1  final borrow; 1 when in1 < in2 + bin.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - start=1 on an edge: latch in1, in2 and bin into internal operand registers.
  - Clear the chunk counter to 0, load the running borrow with bin, go to RUN.
  - start=0: remain in IDLE.
- RUN, each edge:
  - Chunk i covers bits [i*CHUNK +: CHUNK].
  - {b, d} = a_i - b_i - borrow, computed as a (CHUNK+1)-bit subtract.
  - Store d into result bits of chunk i; the running borrow becomes b.
  - Increment the counter.
  - On the edge processing chunk K-1: load dout with the full result, load bout with the final borrow, go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - start=1 on the edge leaving DONE: accept a new operation exactly as from IDLE (go to RUN). This gives back-to-back operation with no idle gap.
  - Otherwise go to IDLE.
- While busy=1, start is ignored; the inputs are not re-sampled.
- dout and bout hold their last values until the next completion. They do not change at the accepting edge, and they do not change during RUN.
- Operands are registered. Input changes after the accepting edge have no effect on the in-flight result.
- No arithmetic exceptions exist: wrap-around is the defined result, and bout flags it.

## Timing
- Reset (rst_n=0, any time, asynchronous):
  - state=IDLE, busy=0, done=0, dout=0, bout=0, counter=0, internal registers cleared.
  - Reset mid-operation aborts the operation; no done pulse follows.
  - The first edge with rst_n=1 may accept start.
- Latency:
  - The accepting edge is E0. busy=1 from E0.
  - Chunks are computed on edges E1..EK.
  - After EK: busy=0, done=1, dout and bout valid.
  - After EK+1: done=0.
  - Default config (K=4): done is visible 4 cycles after the accepting edge.
- Throughput: one operation per K+1 cycles with back-to-back start asserted in the DONE cycle.
- Outputs are driven from registers only; there is no combinational path from any input to any output.

## Test plan
- in1=1010, in2=1000, bin=0 -> dout=10, bout=0. done pulses exactly 4 cycles after the accepting edge and busy is high for exactly 4 cycles.
- in1=1000, in2=1010, bin=0 -> dout=0xFFFFFFF6, bout=1. in1=0xFFFFFFFF, in2=0xFFFFFFFF, bin=1 -> dout=0xFFFFFFFF, bout=1.
- Cross-chunk borrow ripple:
  - in1=0x01000000, in2=0x00000001, bin=0 -> dout=0x00FFFFFF, bout=0.
  - in1=0, in2=0, bin=1 -> dout=0xFFFFFFFF, bout=1.
- start pulsed with new operands (5, 3) during RUN -> ignored. The original result is unaffected and only one done pulse occurs. A held start in the DONE cycle launches (5, 3) -> dout=2 after a further 4 cycles.
- rst_n asserted at compute cycle 2:
  - busy, done, dout and bout go to 0 immediately, and no done pulse occurs afterward.
  - A fresh operation (100, 1, bin=0) after release -> dout=99.
- Randomized operands with CHUNK=8 and CHUNK=4 -> dout and bout match the reference model (in1 - in2 - bin) for 1000 vectors.
